rf_write_buffer: RTL and testbench

- Write-side front end of the register file.
- Collects GPR write requests from two producers and serialises them into the single RF write port, one write per cycle:
  - the W-stage writeback (primary producer)
  - the multi-cycle mult/div unit (secondary producer, mfhi/mflo results)
- Buffers pending writes in a small FIFO.
- Exposes a youngest-match bypass lookup so D-stage readers never see stale RF data while a write is queued.

---
 rtl/rf_write_buffer_pkg.sv | 14 +
 rtl/rf_write_buffer_wq_match.sv | 29 ++
 rtl/rf_write_buffer.sv | 95 +++++++++
 tb/tb_rf_write_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rf_write_buffer_pkg.sv
// rtl/rf_write_buffer_pkg.sv - shared widths and queue entry type for the RF write buffer
package rf_write_buffer_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int PC_W      = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] waddr;
    logic [RF_DATA_W-1:0] data;
    logic [PC_W-1:0]      pc;
  } wq_entry_t;

endpackage

// File: rtl/rf_write_buffer_wq_match.sv
// rtl/rf_write_buffer_wq_match.sv - youngest-first search of pending writes for one read index
module wq_match
  import rf_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  wq_entry_t [DEPTH-1:0] entries,
  input  logic [AW-1:0]         head,
  input  logic [AW:0]           count,
  input  logic [RF_ADDR_W-1:0]  idx,
  output logic                  hit,
  output logic [RF_DATA_W-1:0]  data
);

  // Walk oldest to youngest so a younger match overwrites an older one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((AW+1)'(i) < count) && (idx != '0) &&
          (entries[head + AW'(i)].waddr == idx)) begin
        hit  = 1'b1;
        data = entries[head + AW'(i)].data;
      end
    end
  end

endmodule

// File: rtl/rf_write_buffer.sv
// rtl/rf_write_buffer.sv - serialises W-stage and mult/div GPR writes into the single RF write port
module rf_write_buffer
  import rf_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_valid,
  input  logic [RF_ADDR_W-1:0] wb_reg,
  input  logic [RF_DATA_W-1:0] wb_data,
  input  logic [PC_W-1:0]      wb_pc,
  output logic                 wb_ready,
  input  logic                 md_valid,
  input  logic [RF_ADDR_W-1:0] md_reg,
  input  logic [RF_DATA_W-1:0] md_data,
  input  logic [PC_W-1:0]      md_pc,
  output logic                 md_ready,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [RF_DATA_W-1:0] rf_wdata,
  output logic [PC_W-1:0]      rf_pc,
  input  logic [RF_ADDR_W-1:0] rs,
  input  logic [RF_ADDR_W-1:0] rt,
  output logic                 fwd_rs_hit,
  output logic [RF_DATA_W-1:0] fwd_rs_data,
  output logic                 fwd_rt_hit,
  output logic [RF_DATA_W-1:0] fwd_rt_data,
  output logic                 full
);

  wq_entry_t [DEPTH-1:0] entries;
  logic [AW-1:0]         head;
  logic [AW-1:0]         tail;
  logic [AW:0]           count;

  wq_entry_t push_entry;
  logic      wb_hs;
  logic      md_hs;
  logic      push;
  logic      pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign wb_ready = !full;
  assign md_ready = !full && !wb_valid;
  assign wb_hs    = wb_valid && wb_ready;
  assign md_hs    = md_valid && md_ready;

  assign push_entry = wb_hs ? '{waddr: wb_reg, data: wb_data, pc: wb_pc}
                            : '{waddr: md_reg, data: md_data, pc: md_pc};
  // Writes to $0 complete the handshake but are never queued.
  assign push = (wb_hs || md_hs) && (push_entry.waddr != '0);
  assign pop  = (count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries[tail] <= push_entry;
  end

  assign rf_we    = pop;
  assign rf_waddr = pop ? entries[head].waddr : '0;
  assign rf_wdata = pop ? entries[head].data  : '0;
  assign rf_pc    = pop ? entries[head].pc    : '0;

  wq_match #(.DEPTH(DEPTH), .AW(AW)) u_match_rs (
    .entries (entries),
    .head    (head),
    .count   (count),
    .idx     (rs),
    .hit     (fwd_rs_hit),
    .data    (fwd_rs_data)
  );

  wq_match #(.DEPTH(DEPTH), .AW(AW)) u_match_rt (
    .entries (entries),
    .head    (head),
    .count   (count),
    .idx     (rt),
    .hit     (fwd_rt_hit),
    .data    (fwd_rt_data)
  );

endmodule

// File: tb/tb_rf_write_buffer.sv
// tb/tb_rf_write_buffer.sv - scoreboard bench for rf_write_buffer
module tb_rf_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, md_valid;
  logic [4:0]  wb_reg, md_reg, rs, rt;
  logic [31:0] wb_data, wb_pc, md_data, md_pc;
  logic        wb_ready, md_ready, rf_we, full;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, rf_pc;
  logic        fwd_rs_hit, fwd_rt_hit;
  logic [31:0] fwd_rs_data, fwd_rt_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
  } exp_t;
  exp_t exp_q[$];
  bit   full_prev = 1'b0;

  always #5 clk = ~clk;

  rf_write_buffer #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_pc(wb_pc), .wb_ready(wb_ready),
    .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_pc(md_pc), .md_ready(md_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_pc(rf_pc),
    .rs(rs), .rt(rt),
    .fwd_rs_hit(fwd_rs_hit), .fwd_rs_data(fwd_rs_data),
    .fwd_rt_hit(fwd_rt_hit), .fwd_rt_data(fwd_rt_data),
    .full(full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every RF write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset) begin
      if (rf_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rf_unexpected: got reg %0d data %h, expected no write", rf_waddr, rf_wdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (rf_waddr !== e.a || rf_wdata !== e.d || rf_pc !== e.p) begin
            errors++;
            $display("FAIL rf_write: got %0d/%h/%h, expected %0d/%h/%h",
                     rf_waddr, rf_wdata, rf_pc, e.a, e.d, e.p);
          end
        end
      end
      checks++;
      if ($isunknown({wb_ready, md_ready}) || (full && full_prev)) begin
        errors++;
        $display("FAIL ready_full: got ready %b%b full %b prev %b, expected known and full<=1 cycle",
                 wb_ready, md_ready, full, full_prev);
      end
      full_prev = full;
    end
  end

  task automatic idle();
    wb_valid = 1'b0;
    md_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and holds it until accepted (bounded).
  task automatic send(input bit is_md, input logic [4:0] r, input logic [31:0] d, input logic [31:0] p);
    bit ok = 1'b0;
    int n  = 0;
    if (is_md) begin
      md_valid = 1'b1; md_reg = r; md_data = d; md_pc = p;
    end else begin
      wb_valid = 1'b1; wb_reg = r; wb_data = d; wb_pc = p;
    end
    while (!ok && n < 20) begin
      #1;
      ok = is_md ? md_ready : wb_ready;
      if (ok && r != 5'd0) exp_q.push_back('{a: r, d: d, p: p});
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got no ready after %0d cycles, expected accept", n);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    wb_reg = '0; wb_data = '0; wb_pc = '0;
    md_reg = '0; md_data = '0; md_pc = '0;
    rs = '0; rt = '0;

    // Reset held with a W-stage request pending.
    wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'hDEAD; wb_pc = 32'h10;
    tick(); tick();
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_wb_ready", 32'(wb_ready), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_rf_waddr", 32'(rf_waddr), 32'd0);
    wb_valid = 1'b0;
    #1;
    reset = 1'b0;
    tick(); tick();
    chk("post_reset_rf_we", 32'(rf_we), 32'd0);

    // Single write, visible the cycle after acceptance.
    rs = 5'd8;
    send(1'b0, 5'd8, 32'h12345678, 32'h3000);
    idle();
    chk("single_rf_we", 32'(rf_we), 32'd1);
    chk("single_fwd_hit", 32'(fwd_rs_hit), 32'd1);
    chk("single_fwd_data", fwd_rs_data, 32'h12345678);
    tick();
    chk("single_drained", 32'(rf_we), 32'd0);
    chk("single_fwd_gone", 32'(fwd_rs_hit), 32'd0);

    // W stage beats mult/div when both request together.
    rs = 5'd3;
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'hA; wb_pc = 32'h3100;
    md_valid = 1'b1; md_reg = 5'd3; md_data = 32'hB; md_pc = 32'h3104;
    #1;
    chk("prio_wb_ready", 32'(wb_ready), 32'd1);
    chk("prio_md_ready", 32'(md_ready), 32'd0);
    exp_q.push_back('{a: 5'd3, d: 32'hA, p: 32'h3100});
    tick();
    wb_valid = 1'b0;
    #1;
    chk("prio_md_ready_next", 32'(md_ready), 32'd1);
    chk("prio_fwd_a", fwd_rs_data, 32'hA);
    exp_q.push_back('{a: 5'd3, d: 32'hB, p: 32'h3104});
    tick();
    md_valid = 1'b0;
    chk("prio_fwd_b", fwd_rs_data, 32'hB);
    tick();

    // Writes to $0 are accepted but never queued.
    rs = 5'd0;
    send(1'b0, 5'd0, 32'hFFFFFFFF, 32'h3200);
    idle();
    chk("zero_rf_we", 32'(rf_we), 32'd0);
    chk("zero_fwd_hit", 32'(fwd_rs_hit), 32'd0);
    tick();

    // Back-to-back mult/div writes walk the pointers past DEPTH-1.
    for (int i = 1; i <= 6; i++)
      send(1'b1, 5'(i), 32'h100 + 32'(i), 32'h4000 + 32'(4 * i));
    idle();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    chk("fill_drained", 32'(exp_q.size()), 32'd0);
    tick();

    // Asynchronous reset between edges discards the pending write.
    rt = 5'd10;
    wb_valid = 1'b1; wb_reg = 5'd10; wb_data = 32'hCAFE; wb_pc = 32'h5000;
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    #1;
    chk("mid_pre_rf_we", 32'(rf_we), 32'd1);
    chk("mid_pre_fwd_rt", 32'(fwd_rt_hit), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rf_we_async", 32'(rf_we), 32'd0);
    chk("mid_fwd_rt", 32'(fwd_rt_hit), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    tick(); tick();
    chk("mid_after_rf_we", 32'(rf_we), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
